// File: rtl/riscv_defs.sv
// riscv_defs: shared RV32 widths, divider state encodings and divider constants
package riscv_defs;
  localparam int XLEN = 32;
  localparam int DIV_ITER = XLEN;
  localparam logic [XLEN-1:0] DIV_ZERO_QUOTIENT = '1;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_CALC = 2'd2,
    DIV_END  = 2'd3
  } div_state_e;
endpackage

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; DIV_EARLY_EXIT_EN skips iteration when |dividend| < |divisor|
module div_unit #(
  parameter int XLEN = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic            rem_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            annul_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic            stallreq_o
);
  import riscv_defs::*;
  div_state_e state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] quo, dvs, raw, prem;
  logic q_neg, r_neg, rem_sel;
  logic [XLEN-1:0] a_abs, b_abs, quo_nx, prem_nx, q_fin, r_fin;
  logic [XLEN:0] shf, diff;
  // operand magnitudes, one restoring step and the sign fix-up of the last step
  always_comb begin
    a_abs = (signed_i & dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
    b_abs = (signed_i & divisor_i[XLEN-1]) ? -divisor_i : divisor_i;
    shf = {prem, quo[XLEN-1]};
    diff = shf - {1'b0, dvs};
    prem_nx = diff[XLEN] ? shf[XLEN-1:0] : diff[XLEN-1:0];
    quo_nx = {quo[XLEN-2:0], ~diff[XLEN]};
    q_fin = q_neg ? -quo_nx : quo_nx;
    r_fin = r_neg ? -prem_nx : prem_nx;
  end
  assign stallreq_o = ~annul_i & ((state == DIV_IDLE) ? start_i : (state == DIV_ZERO || state == DIV_CALC));
  // control FSM with the iteration datapath and registered result/ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt <= '0;
      quo <= '0;
      dvs <= '0;
      raw <= '0;
      prem <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      rem_sel <= 1'b0;
      result_o <= '0;
      ready_o <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      if (annul_i) state <= DIV_IDLE;
      else case (state)
        DIV_IDLE: if (start_i) begin
          quo <= a_abs;
          dvs <= b_abs;
          raw <= dividend_i;
          prem <= '0;
          cnt <= '0;
          q_neg <= signed_i & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
          r_neg <= signed_i & dividend_i[XLEN-1];
          rem_sel <= rem_i;
          if (divisor_i == '0) state <= DIV_ZERO;
`ifdef DIV_EARLY_EXIT_EN
          else if (a_abs < b_abs) begin
            result_o <= rem_i ? dividend_i : '0;
            ready_o <= 1'b1;
            state <= DIV_END;
          end
`endif
          else state <= DIV_CALC;
        end
        DIV_ZERO: begin
          result_o <= rem_sel ? raw : '1;
          ready_o <= 1'b1;
          state <= DIV_END;
        end
        DIV_CALC: begin
          quo <= quo_nx;
          prem <= prem_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_ITER - 1)) begin
            result_o <= rem_sel ? r_fin : q_fin;
            ready_o <= 1'b1;
            state <= DIV_END;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end
endmodule
